conv_sched: RTL
===============

# conv_sched

Sequencing controller for a P-lane 1-D convolution datapath: x memories (one per lane, 1-cycle read latency), the shared filter ROM, and P saturating MACs. It loads one SIZE_X-sample vector through a valid/ready input port, then computes the SIZE_X-SIZE_F+1 outputs in groups of P, one filter tap per cycle. Each finished group is presented lane by lane through a valid/ready output port with a lane select. Every address, enable and clear in the datapath comes from this block; it holds no sample data.

## Interface
- SIZE_X, 96, input vector length
- SIZE_F, 65, filter length
- P, 2, parallel MAC lanes
- MAC_LAT, 3, cycles from a MAC valid_in to its accumulator update
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- x_valid  in  1  input sample offered
- x_ready  out  1  block accepts a sample (LOAD only)
- wr_en_x  out  1  write strobe to all x memories, = x_valid & x_ready
- addr_x  out  clog2(SIZE_X)  write address in LOAD; group base in all other states
- tap  out  clog2(SIZE_F)  current tap k; lane i reads x at addr_x+tap+i
- addr_f  out  clog2(SIZE_F)  filter ROM address (= tap)
- en_acc  out  1  MAC valid_in, tap issue delayed 1 cycle
- clear_acc  out  1  MAC reset/clear
- lane_mask  out  P  lanes holding a real output in the current group
- y_valid  out  1  result of lane y_sel available
- y_ready  in  1  downstream accepts
- y_sel  out  clog2(P) (min 1)  lane being presented

## Operation
- Definitions: NPTS = SIZE_X-SIZE_F+1; G = ceil(NPTS/P). The last group has NPTS-(G-1)·P lanes and lane_mask holds ones in that many low bits; every other group has all lanes set.
- States:
  - LOAD: x_ready=1, clear_acc=1. Each accepted sample writes addr_x = load count. After SIZE_X accepts, addr_x←0 and the block goes to COMPUTE.
  - COMPUTE: tap runs 0..SIZE_F-1, one per cycle. After the last tap the block goes to DRAIN.
  - DRAIN: waits MAC_LAT cycles after the last en_acc, then goes to OUT.
  - OUT: y_valid=1, y_sel=lane. Each y_valid&&y_ready advances the lane.
    - After the last lane in lane_mask, if this was not the last group: go to CLEAR and addr_x += P.
    - After the last lane of the last group: go to LOAD.
  - CLEAR: clear_acc=1 for one cycle, then COMPUTE with tap=0.
- clear_acc=0 in COMPUTE, DRAIN and OUT.
- en_acc is the COMPUTE-state flag registered once, so it lines up with the 1-cycle x/ROM reads.
- x_valid is ignored outside LOAD.
- y_ready is ignored outside OUT.
- Arithmetic: counters are unsigned with exact terminal compares, no wrap. addr_x never exceeds (G-1)·P. The datapath must not read x addresses ≥ SIZE_X on masked lanes; it gates those lanes with lane_mask.

## Timing
- Reset values:
  - state=LOAD, x_ready=1, clear_acc=1
  - en_acc=0, y_valid=0, wr_en_x=0
  - addr_x=0, tap=0, addr_f=0, y_sel=0
  - lane_mask = all ones, or the partial mask if G=1
- Reset asserted in any state returns to these values on the next edge. A partial load is discarded.
- Entry to COMPUTE is the cycle after the SIZE_X-th accept.
- en_acc is high for exactly SIZE_F consecutive cycles, starting 1 cycle after entry to COMPUTE.
- The first y_valid rises SIZE_F+1+MAC_LAT cycles after entry to COMPUTE.
- In OUT with y_ready held high, one result is presented per cycle.
- With y_ready low, y_valid, y_sel and addr_x hold indefinitely.
- Once y_valid is asserted it stays asserted until accepted; there is no withdrawal.
- Back-to-back groups: the last output handshake, then 1 CLEAR cycle, then COMPUTE.
- Last group: the cycle after its final handshake is LOAD with x_ready=1. The next vector may stream in immediately.

## Structure
- Shared package conv_pkg holds:
  - state enum (LOAD, COMPUTE, DRAIN, OUT, CLEAR)
  - functions npts(SIZE_X,SIZE_F), groups(NPTS,P), last_mask(NPTS,P)
  - width localparams via $clog2
- One sub-module, conv_sched_cnt: a parameterised up-counter with clear, enable and terminal-count flag. It is instantiated for the load/tap, drain and lane counters.
- The group counter and the addr_x base live in conv_sched itself.

## Test plan
- Defaults, x_valid always high, y_ready always high:
  - x_ready drops after exactly 96 accepts.
  - en_acc is high for 65 cycles.
  - first y_valid comes 69 cycles after COMPUTE entry.
  - 32 outputs, y_sel alternating 0,1.
  - addr_x steps 0,2,…,30.
  - after the 32nd handshake, x_ready=1.
- SIZE_X=10, SIZE_F=4, P=3 (NPTS=7, G=3): last group lane_mask=3'b001, and OUT takes exactly 1 handshake before LOAD.
- y_ready low for 20 cycles mid-group: y_valid, y_sel and addr_x stay constant and no handshake is lost. Totals still equal 32.
- x_valid toggled randomly at 50% during LOAD: wr_en_x count=96, with addr_x sequential 0..95 and no gaps.
- Reset pulsed during COMPUTE at tap=30: on the next cycle state=LOAD, en_acc=0, clear_acc=1, tap=0. A full reload then produces normal output.
- x_valid high during OUT: wr_en_x stays 0 and x_ready stays 0.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and geometry helpers for the convolution sequencer
package conv_pkg;

    typedef enum logic [2:0] {
        LOAD,
        COMPUTE,
        DRAIN,
        OUT,
        CLEAR
    } state_t;

    function automatic int wbits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int npts(input int size_x, input int size_f);
        return size_x - size_f + 1;
    endfunction

    function automatic int groups(input int n, input int p);
        return (n + p - 1) / p;
    endfunction

    // Low-bit mask covering the lanes that hold real outputs in the final group
    function automatic logic [31:0] last_mask(input int n, input int p);
        int lanes;
        lanes = n - (groups(n, p) - 1) * p;
        return (32'd1 << lanes) - 32'd1;
    endfunction

endpackage

// File: rtl/conv_sched_cnt.sv
// rtl/conv_sched_cnt.sv - up-counter with clear, enable and terminal-count flag
module conv_sched_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == last);

    // Holds at the terminal value; the owner clears it on its state change
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - load/compute/drain/output sequencer for a P-lane 1-D convolution datapath
module conv_sched
    import conv_pkg::*;
#(
    parameter int SIZE_X  = 96,
    parameter int SIZE_F  = 65,
    parameter int P       = 2,
    parameter int MAC_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     x_valid,
    output logic                     x_ready,
    output logic                     wr_en_x,
    output logic [wbits(SIZE_X)-1:0] addr_x,
    output logic [wbits(SIZE_F)-1:0] tap,
    output logic [wbits(SIZE_F)-1:0] addr_f,
    output logic                     en_acc,
    output logic                     clear_acc,
    output logic [P-1:0]             lane_mask,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic [wbits(P)-1:0]      y_sel
);

    localparam int AXW   = wbits(SIZE_X);
    localparam int TW    = wbits(SIZE_F);
    localparam int YW    = wbits(P);
    localparam int LTW   = (AXW > TW) ? AXW : TW;
    localparam int DW    = wbits(MAC_LAT + 1);
    localparam int NPTS  = npts(SIZE_X, SIZE_F);
    localparam int G     = groups(NPTS, P);
    localparam int GW    = wbits(G);
    localparam int NLAST = NPTS - (G - 1) * P;
    localparam logic [P-1:0] LMASK = P'(last_mask(NPTS, P));

    state_t state, next_state;

    logic [LTW-1:0] lt_cnt, lt_last;
    logic           lt_tc, lt_clr, lt_en;
    logic [DW-1:0]  drain_cnt_unused;
    logic           drain_tc;
    logic [YW-1:0]  lane_cnt, lane_last;
    logic           lane_tc;
    logic [GW-1:0]  group;
    logic [AXW-1:0] base;
    logic           last_group, hs, group_done;

    assign last_group = (group == GW'(G - 1));
    assign x_ready    = (state == LOAD);
    assign wr_en_x    = x_valid & x_ready;
    assign clear_acc  = (state == LOAD) || (state == CLEAR);
    assign y_valid    = (state == OUT);
    assign y_sel      = lane_cnt;
    assign hs         = y_valid & y_ready;
    assign group_done = hs & lane_tc;
    assign tap        = (state == COMPUTE) ? lt_cnt[TW-1:0] : '0;
    assign addr_f     = tap;
    assign addr_x     = (state == LOAD) ? lt_cnt[AXW-1:0] : base;
    assign lane_mask  = last_group ? LMASK : '1;

    // One counter serves as load address in LOAD and tap index in COMPUTE
    assign lt_last   = (state == LOAD) ? LTW'(SIZE_X - 1) : LTW'(SIZE_F - 1);
    assign lt_en     = wr_en_x || (state == COMPUTE);
    assign lt_clr    = (next_state != state);
    assign lane_last = last_group ? YW'(NLAST - 1) : YW'(P - 1);

    conv_sched_cnt #(.W(LTW)) u_lt_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (lt_clr),
        .en    (lt_en),
        .last  (lt_last),
        .count (lt_cnt),
        .tc    (lt_tc)
    );

    conv_sched_cnt #(.W(DW)) u_drain_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state != DRAIN),
        .en    (state == DRAIN),
        .last  (DW'(MAC_LAT)),
        .count (drain_cnt_unused),
        .tc    (drain_tc)
    );

    conv_sched_cnt #(.W(YW)) u_lane_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state != OUT),
        .en    (hs),
        .last  (lane_last),
        .count (lane_cnt),
        .tc    (lane_tc)
    );

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (wr_en_x && lt_tc) next_state = COMPUTE;
            COMPUTE: if (lt_tc) next_state = DRAIN;
            DRAIN:   if (drain_tc) next_state = OUT;
            OUT:     if (group_done) next_state = last_group ? LOAD : CLEAR;
            CLEAR:   next_state = COMPUTE;
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOAD;
            en_acc <= 1'b0;
            group  <= '0;
            base   <= '0;
        end else begin
            state  <= next_state;
            en_acc <= (state == COMPUTE);
            if (state == OUT && group_done) begin
                if (last_group) begin
                    group <= '0;
                    base  <= '0;
                end else begin
                    group <= group + 1'b1;
                    base  <= base + AXW'(P);
                end
            end
        end
    end

endmodule
